// File: rtl/jk_counter_ctrl_pkg.sv
// Shared encodings for the JK-cell counter sequencer: FSM state codes and
// the J/K operation codes understood by every cell in the bank.
package jk_counter_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_counter_ctrl_if.sv
// Control/status bundle between a client and the JK counter sequencer.
interface jk_counter_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             abort;
  logic             hold;
  logic             up_dn;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, hold, up_dn, load_val, terminal,
    input  count, busy, done
  );

  modport slave (
    input  start, abort, hold, up_dn, load_val, terminal,
    output count, busy, done
  );
endinterface

// File: rtl/jk_counter_ctrl_jk_cell.sv
// Single JK flip-flop: hold / reset / set / toggle on the rising clock edge,
// cleared asynchronously while rst is low.
module jk_cell
  import jk_counter_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case ({j, k})
      JK_HOLD: q_d = q_q;
      JK_RST:  q_d = 1'b0;
      JK_SET:  q_d = 1'b1;
      JK_TGL:  q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_counter_ctrl.sv
// Sequencer driving a bank of JK cells as a loadable up/down counter that
// runs from a seed to a terminal value and pulses done on arrival.
module jk_counter_ctrl
  import jk_counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  jk_counter_ctrl_if.slave  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [WIDTH-1:0] count_vec;
  logic [WIDTH-1:0] t_up, t_dn, t_vec, step_val;
  logic [WIDTH-1:0] j_vec, k_vec;

  genvar gi;

  // Synchronous-counter toggle terms: a bit flips when all lower bits are
  // 1 (counting up) or all 0 (counting down).
  assign t_up[0] = 1'b1;
  assign t_dn[0] = 1'b1;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_tvec
      assign t_up[gi] = &count_vec[gi-1:0];
      assign t_dn[gi] = &(~count_vec[gi-1:0]);
    end
  endgenerate

  assign t_vec    = bus.up_dn ? t_up : t_dn;
  assign step_val = count_vec ^ t_vec;

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
        .clk (clk),
        .rst (rst),
        .j   (j_vec[gi]),
        .k   (k_vec[gi]),
        .q   (count_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    term_d  = term_q;
    j_vec   = '0;
    k_vec   = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          seed_d  = bus.load_val;
          term_d  = bus.terminal;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.abort) begin
          k_vec   = '1;
          state_d = ST_IDLE;
        end else begin
          j_vec   = seed_q;
          k_vec   = ~seed_q;
          state_d = (seed_q == term_q) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // abort wins over hold and over reaching terminal on this edge
        if (bus.abort) begin
          k_vec   = '1;
          state_d = ST_IDLE;
        end else if (!bus.hold) begin
          j_vec = t_vec;
          k_vec = t_vec;
          if (step_val == term_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      seed_q  <= '0;
      term_q  <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      term_q  <= term_d;
    end
  end

  assign bus.count = count_vec;
  assign bus.busy  = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign bus.done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Scoreboard bench for jk_counter_ctrl: directed runs push per-cycle expected
// count/busy/done into a queue that an independent monitor drains.
module tb_jk_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  cnt;
    logic        busy;
    logic        done;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  jk_counter_ctrl_if #(.WIDTH(4)) bus ();

  jk_counter_ctrl #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int unsigned at, input logic [3:0] c,
                      input logic b, input logic d, input string tag);
    exp_t e;
    e.cyc  = at;
    e.cnt  = c;
    e.busy = b;
    e.done = d;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [3:0] seed, input logic [3:0] term, input logic up);
    bus.load_val = seed;
    bus.terminal = term;
    bus.up_dn    = up;
    bus.start    = 1'b1;
  endtask

  // Monitor: samples away from the clock edge, and also right after an
  // asynchronous reset assertion, comparing every entry due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or negedge rst);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_vec++;
        if (e.cyc < cyc) begin
          n_bad++;
          $display("FAIL %s: sample for cycle %0d missed (now cycle %0d)", e.tag, e.cyc, cyc);
        end else if (bus.count !== e.cnt || bus.busy !== e.busy || bus.done !== e.done) begin
          n_bad++;
          $display("FAIL %s cyc=%0d: got count=%0d busy=%b done=%b, expected count=%0d busy=%b done=%b",
                   e.tag, cyc, bus.count, bus.busy, bus.done, e.cnt, e.busy, e.done);
        end else begin
          $display("ok   %s cyc=%0d count=%0d busy=%b done=%b", e.tag, cyc, bus.count, bus.busy, bus.done);
        end
      end
    end
  end

  initial begin
    int unsigned base;
    exp_t        e;
    bus.start = 1'b0; bus.abort = 1'b0; bus.hold = 1'b0; bus.up_dn = 1'b1;
    bus.load_val = '0; bus.terminal = '0;

    // reset state
    tick();
    push(cyc, 4'd0, 1'b0, 1'b0, "reset");
    tick();
    rst = 1'b1;
    tick();

    // 1: async reset mid-run at count=5
    base = cyc;
    go(4'd2, 4'd12, 1'b1);
    push(base+1, 4'd0, 1, 0, "t1_load");
    push(base+2, 4'd2, 1, 0, "t1_c2");
    push(base+3, 4'd3, 1, 0, "t1_c3");
    push(base+4, 4'd4, 1, 0, "t1_c4");
    push(base+5, 4'd5, 1, 0, "t1_c5");
    tick(); bus.start = 1'b0;
    repeat (4) tick();
    @(negedge clk); #2;
    push(cyc, 4'd0, 0, 0, "t1_rst_async");
    rst = 1'b0;
    tick();
    push(cyc, 4'd0, 0, 0, "t1_rst_held");
    rst = 1'b1;
    tick();

    // 2: up 3 -> 7
    base = cyc;
    go(4'd3, 4'd7, 1'b1);
    push(base+1, 4'd0, 1, 0, "t2_load");
    push(base+2, 4'd3, 1, 0, "t2_c3");
    push(base+3, 4'd4, 1, 0, "t2_c4");
    push(base+4, 4'd5, 1, 0, "t2_c5");
    push(base+5, 4'd6, 1, 0, "t2_c6");
    push(base+6, 4'd7, 0, 1, "t2_done");
    push(base+7, 4'd7, 0, 0, "t2_idle");
    tick(); bus.start = 1'b0;
    repeat (6) tick();

    // 3: down 1 -> 14 through the 0 -> 15 wrap
    base = cyc;
    go(4'd1, 4'd14, 1'b0);
    push(base+1, 4'd7,  1, 0, "t3_load");
    push(base+2, 4'd1,  1, 0, "t3_c1");
    push(base+3, 4'd0,  1, 0, "t3_c0");
    push(base+4, 4'd15, 1, 0, "t3_c15");
    push(base+5, 4'd14, 0, 1, "t3_done");
    push(base+6, 4'd14, 0, 0, "t3_idle");
    tick(); bus.start = 1'b0;
    repeat (5) tick();

    // 4: up 0 -> 9 with hold for 3 cycles at count=4
    base = cyc;
    go(4'd0, 4'd9, 1'b1);
    push(base+1,  4'd14, 1, 0, "t4_load");
    push(base+2,  4'd0,  1, 0, "t4_c0");
    push(base+3,  4'd1,  1, 0, "t4_c1");
    push(base+4,  4'd2,  1, 0, "t4_c2");
    push(base+5,  4'd3,  1, 0, "t4_c3");
    push(base+6,  4'd4,  1, 0, "t4_c4");
    push(base+7,  4'd4,  1, 0, "t4_hold1");
    push(base+8,  4'd4,  1, 0, "t4_hold2");
    push(base+9,  4'd4,  1, 0, "t4_hold3");
    push(base+10, 4'd5,  1, 0, "t4_c5");
    push(base+11, 4'd6,  1, 0, "t4_c6");
    push(base+12, 4'd7,  1, 0, "t4_c7");
    push(base+13, 4'd8,  1, 0, "t4_c8");
    push(base+14, 4'd9,  0, 1, "t4_done");
    push(base+15, 4'd9,  0, 0, "t4_idle");
    tick(); bus.start = 1'b0;
    repeat (5) tick();
    bus.hold = 1'b1;
    repeat (3) tick();
    bus.hold = 1'b0;
    repeat (6) tick();

    // 5: start while busy ignored, abort at count=6
    base = cyc;
    go(4'd2, 4'd11, 1'b1);
    push(base+1, 4'd9, 1, 0, "t5_load");
    push(base+2, 4'd2, 1, 0, "t5_c2");
    push(base+3, 4'd3, 1, 0, "t5_c3");
    push(base+4, 4'd4, 1, 0, "t5_c4_start_ignored");
    push(base+5, 4'd5, 1, 0, "t5_c5");
    push(base+6, 4'd6, 1, 0, "t5_c6");
    push(base+7, 4'd0, 0, 0, "t5_aborted");
    push(base+8, 4'd0, 0, 0, "t5_no_done");
    push(base+9, 4'd0, 0, 0, "t5_idle");
    tick(); bus.start = 1'b0;
    tick();
    tick(); go(4'd0, 4'd5, 1'b1);
    tick(); bus.start = 1'b0;
    tick();
    tick(); bus.abort = 1'b1;
    tick(); bus.abort = 1'b0;
    repeat (2) tick();

    // 6: seed == terminal, start re-pulsed in DONE must be ignored
    base = cyc;
    go(4'd10, 4'd10, 1'b1);
    push(base+1, 4'd0,  1, 0, "t6_load");
    push(base+2, 4'd10, 0, 1, "t6_done");
    push(base+3, 4'd10, 0, 0, "t6_idle_start_ignored");
    push(base+4, 4'd10, 0, 0, "t6_idle");
    tick(); bus.start = 1'b0;
    tick(); bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    tick();

    // 7: abort while in LOAD
    base = cyc;
    go(4'd5, 4'd8, 1'b1);
    push(base+1, 4'd10, 1, 0, "t7_load");
    push(base+2, 4'd0,  0, 0, "t7_aborted");
    push(base+3, 4'd0,  0, 0, "t7_idle");
    tick(); bus.start = 1'b0; bus.abort = 1'b1;
    tick(); bus.abort = 1'b0;
    tick();

    // 8: up 14 -> 1 through the 15 -> 0 wrap
    base = cyc;
    go(4'd14, 4'd1, 1'b1);
    push(base+1, 4'd0,  1, 0, "t8_load");
    push(base+2, 4'd14, 1, 0, "t8_c14");
    push(base+3, 4'd15, 1, 0, "t8_c15");
    push(base+4, 4'd0,  1, 0, "t8_c0");
    push(base+5, 4'd1,  0, 1, "t8_done");
    push(base+6, 4'd1,  0, 0, "t8_idle");
    tick(); bus.start = 1'b0;
    repeat (5) tick();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s: never sampled (due cycle %0d, now %0d)", e.tag, e.cyc, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
